// File: rtl/phased_cache_pkg.sv
// phased_cache_pkg: shared state type, way geometry and bit-vector helpers
// for the phased cache sequencer and fill controller.
package phased_cache_pkg;

    localparam int NUM_WAYS = 16;
    localparam int WAY_W    = 4;

    typedef enum logic [2:0] {IDLE, TAG, CMP, DATA, RESP} state_t;

    function automatic logic [WAY_W:0] popcount(input logic [NUM_WAYS-1:0] v);
        logic [WAY_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_WAYS; i++) n = n + {{WAY_W{1'b0}}, v[i]};
        return n;
    endfunction

    // Lowest set bit wins; an all-zero vector encodes to way 0.
    function automatic logic [WAY_W-1:0] encode(input logic [NUM_WAYS-1:0] v);
        logic [WAY_W-1:0] w;
        w = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) if (v[i]) w = i[WAY_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/phased_cache_ctrl_if.sv
// phased_cache_ctrl_if: core request/response port plus tag/data array strobes;
// slave is the controller, master is the core/array side.
interface phased_cache_ctrl_if #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 20
);
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [15:0]        way_mask;
    logic               tag_rd_en;
    logic [INDEX_W-1:0] tag_rd_index;
    logic [15:0]        tag_hit_vec;
    logic [15:0]        data_en;
    logic               data_we;
    logic [INDEX_W-1:0] data_index;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_hit;
    logic               resp_err;
    logic [3:0]         resp_way;
    logic [TAG_W-1:0]   resp_tag;

    modport master (
        output req_valid, req_write, req_index, req_tag, way_mask, tag_hit_vec, resp_ready,
        input  req_ready, tag_rd_en, tag_rd_index, data_en, data_we, data_index,
               resp_valid, resp_hit, resp_err, resp_way, resp_tag
    );

    modport slave (
        input  req_valid, req_write, req_index, req_tag, way_mask, tag_hit_vec, resp_ready,
        output req_ready, tag_rd_en, tag_rd_index, data_en, data_we, data_index,
               resp_valid, resp_hit, resp_err, resp_way, resp_tag
    );
endinterface

// File: rtl/decoder4to16.sv
// decoder4to16: enabled binary-to-one-hot decoder.
module decoder4to16 (
    input  logic        en,
    input  logic [3:0]  in,
    output logic [15:0] out
);
    assign out = en ? 16'(1) << in : '0;
endmodule

// File: rtl/phased_cache_ctrl.sv
// phased_cache_ctrl: tag-then-data sequencer for the 16-way phased cache; only the
// single hit way's data array is enabled, and a rotating pointer picks miss victims.
module phased_cache_ctrl
    import phased_cache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 20
) (
    input logic                clk,
    input logic                rst_n,
    phased_cache_ctrl_if.slave bus
);
    state_t             state, state_n;
    logic               wr, hit, err, hit_n, err_n;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WAY_W-1:0]   way, way_n, ptr, victim;
    logic [NUM_WAYS-1:0] hv, rot;
    logic [WAY_W:0]     cnt;

    // Rotate the mask so the pointer sits at bit 0, then take the lowest enabled way.
    always_comb begin
        hv     = bus.tag_hit_vec & bus.way_mask;
        cnt    = popcount(hv);
        rot    = NUM_WAYS'({bus.way_mask, bus.way_mask} >> ptr);
        victim = ptr + encode(rot);
        err_n  = bus.way_mask == '0 || cnt > 5'd1;
        hit_n  = !err_n && cnt == 5'd1;
        way_n  = hit_n ? encode(hv) : err_n ? '0 : victim;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.req_valid ? TAG : IDLE;
            TAG:     state_n = CMP;
            CMP:     state_n = hit_n ? DATA : RESP;
            DATA:    state_n = RESP;
            RESP:    state_n = bus.resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wr    <= 1'b0;
            idx   <= '0;
            tag   <= '0;
            way   <= '0;
            hit   <= 1'b0;
            err   <= 1'b0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.req_valid) begin
                wr  <= bus.req_write;
                idx <= bus.req_index;
                tag <= bus.req_tag;
            end
            if (state == CMP) begin
                way <= way_n;
                hit <= hit_n;
                err <= err_n;
            end
            if (state == RESP && bus.resp_ready && !hit && !err) ptr <= way + 1'b1;
        end
    end

    decoder4to16 u_dec (
        .en  (state == DATA),
        .in  (way),
        .out (bus.data_en)
    );

    assign bus.req_ready    = state == IDLE;
    assign bus.tag_rd_en    = state == TAG;
    assign bus.tag_rd_index = state == TAG ? idx : '0;
    assign bus.data_we      = state == DATA && wr;
    assign bus.data_index   = state == DATA ? idx : '0;
    assign bus.resp_valid   = state == RESP;
    assign bus.resp_hit     = state == RESP && hit;
    assign bus.resp_err     = state == RESP && err;
    assign bus.resp_way     = state == RESP ? way : '0;
    assign bus.resp_tag     = state == RESP ? tag : '0;
endmodule
